// File: rtl/cpu_debug_pkg.sv
// Shared encodings for the end-of-run dump engine: FSM states, trigger causes and beat kinds.
package cpu_debug_pkg;

  localparam int DUMP_IDX_W = 8;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_REG  = 2'd1,
    ST_MEM  = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_CYCLES = 2'd1,
    CAUSE_HALT   = 2'd2,
    CAUSE_EXT    = 2'd3
  } dump_cause_e;

  typedef enum logic {
    KIND_REG = 1'b0,
    KIND_MEM = 1'b1
  } dump_kind_e;

endpackage

// File: rtl/halt_detector.sv
// Flags a halted CPU: pulses 'halt' combinationally on the fetch that makes the PC repeat HALT_STABLE times.
// Latency: same cycle as that fetch; no backpressure.
module halt_detector
  import cpu_debug_pkg::*;
#(
  parameter int HALT_STABLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        halt
);

  localparam int SW = (HALT_STABLE < 1) ? 1 : $clog2(HALT_STABLE + 1);
  localparam logic [SW-1:0] LIM    = SW'(HALT_STABLE);
  localparam logic [SW-1:0] LIM_M1 = (HALT_STABLE < 1) ? '0 : SW'(HALT_STABLE - 1);

  logic [31:0]   last_pc;
  logic [SW-1:0] stable;
  logic          same;

  assign same = pc_valid && (pc == last_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pc <= '0;
      stable  <= '0;
    end else if (pc_valid) begin
      last_pc <= pc;
      if (!same)
        stable <= '0;
      else if (stable != LIM)
        stable <= stable + SW'(1);
    end
  end

  // Fires only on the transition into the limit, so a saturated counter does not re-trigger.
  assign halt = (HALT_STABLE != 0) && same && (stable == LIM_M1);

endmodule

// File: rtl/run_dump_sequencer.sv
// End-of-run dump: on ext/cycle-limit/halt trigger, freezes the CPU and streams regs then a memory window.
// Latency: first beat the cycle after the trigger; stalls hold every dump output and read address stable.
module run_dump_sequencer
  import cpu_debug_pkg::*;
#(
  parameter int          MAX_CYCLES  = 45,
  parameter int          HALT_STABLE = 4,
  parameter int          REG_COUNT   = 32,
  parameter int          MEM_WORDS   = 9,
  parameter logic [31:0] DATA_BASE   = 32'h0000_0000,
  parameter int          CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc,
  input  logic                  pc_valid,
  input  logic                  ext_trig,
  output logic                  cpu_freeze,
  output logic [4:0]            rf_raddr,
  input  logic [31:0]           rf_rdata,
  output logic [31:0]           dm_raddr,
  input  logic [31:0]           dm_rdata,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic                  dump_kind,
  output logic [DUMP_IDX_W-1:0] dump_index,
  output logic [31:0]           dump_data,
  output logic [1:0]            dump_cause,
  output logic                  done,
  output logic [CNT_W-1:0]      cycle_count
);

  localparam logic [DUMP_IDX_W-1:0] REG_LAST  = DUMP_IDX_W'(REG_COUNT - 1);
  localparam logic [DUMP_IDX_W-1:0] MEM_LAST  = (MEM_WORDS > 0) ? DUMP_IDX_W'(MEM_WORDS - 1) : '0;
  localparam logic [CNT_W-1:0]      CYC_LIMIT = CNT_W'(MAX_CYCLES);

  if (MEM_WORDS > 255 || MEM_WORDS < 0 || REG_COUNT < 1 || REG_COUNT > 32) begin : g_param_check
    $error("run_dump_sequencer: REG_COUNT must be 1..32 and MEM_WORDS 0..255");
  end

  dump_state_e           state, state_nxt;
  dump_cause_e           cause, cause_nxt;
  logic [DUMP_IDX_W-1:0] idx, idx_nxt;
  logic                  halt;
  logic                  cyc_hit;

  halt_detector #(.HALT_STABLE(HALT_STABLE)) u_halt (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .pc_valid (pc_valid),
    .halt     (halt)
  );

  // Compare against count+1 so the counter lands exactly on MAX_CYCLES when it stops.
  assign cyc_hit = (MAX_CYCLES != 0) && ((cycle_count + CNT_W'(1)) == CYC_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      cause       <= CAUSE_NONE;
      idx         <= '0;
      cycle_count <= '0;
    end else begin
      state <= state_nxt;
      cause <= cause_nxt;
      idx   <= idx_nxt;
      if (state == ST_RUN && cycle_count != '1)
        cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  assign dump_cause = cause;

  always_comb begin
    state_nxt  = state;
    cause_nxt  = cause;
    idx_nxt    = idx;
    cpu_freeze = (state != ST_RUN);
    done       = 1'b0;
    dump_valid = 1'b0;
    dump_kind  = KIND_REG;
    dump_index = '0;
    dump_data  = '0;
    rf_raddr   = '0;
    dm_raddr   = DATA_BASE;
    unique case (state)
      ST_RUN: begin
        if (ext_trig)     cause_nxt = CAUSE_EXT;
        else if (cyc_hit) cause_nxt = CAUSE_CYCLES;
        else if (halt)    cause_nxt = CAUSE_HALT;
        if (ext_trig || cyc_hit || halt) begin
          state_nxt = ST_REG;
          idx_nxt   = '0;
        end
      end
      ST_REG: begin
        rf_raddr   = idx[4:0];
        dump_valid = 1'b1;
        dump_index = idx;
        dump_data  = (idx == '0) ? '0 : rf_rdata;
        if (dump_ready) begin
          if (idx == REG_LAST) begin
            idx_nxt   = '0;
            state_nxt = (MEM_WORDS == 0) ? ST_DONE : ST_MEM;
          end else begin
            idx_nxt = idx + DUMP_IDX_W'(1);
          end
        end
      end
      ST_MEM: begin
        dm_raddr   = DATA_BASE + {22'b0, idx, 2'b00};
        dump_valid = 1'b1;
        dump_kind  = KIND_MEM;
        dump_index = idx;
        dump_data  = dm_rdata;
        if (dump_ready) begin
          if (idx == MEM_LAST) state_nxt = ST_DONE;
          else                 idx_nxt   = idx + DUMP_IDX_W'(1);
        end
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_run_dump_sequencer.sv
// Bench for run_dump_sequencer: two configurations, behavioural beat/trigger model checked every cycle.
`timescale 1ns/1ps
module tb_run_dump_sequencer;

  localparam int NDUT = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [NDUT];
  logic [31:0] pc         [NDUT];
  logic        pc_valid   [NDUT];
  logic        ext_trig   [NDUT];
  logic        cpu_freeze [NDUT];
  logic [4:0]  rf_raddr   [NDUT];
  logic [31:0] rf_rdata   [NDUT];
  logic [31:0] dm_raddr   [NDUT];
  logic [31:0] dm_rdata   [NDUT];
  logic        dump_valid [NDUT];
  logic        dump_ready [NDUT];
  logic        dump_kind  [NDUT];
  logic [7:0]  dump_index [NDUT];
  logic [31:0] dump_data  [NDUT];
  logic [1:0]  dump_cause [NDUT];
  logic        done       [NDUT];
  logic [31:0] cycle_count[NDUT];

  function automatic logic [31:0] rfv(input logic [4:0] a);
    return 32'h1000_0000 + {27'b0, a} * 32'h0101_0111;
  endfunction

  function automatic logic [31:0] memv(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction

  // Configuration 0: defaults. Configuration 1: no cycle limit, 4 registers, no memory phase.
  function automatic int p_max(input int d);          return (d == 0) ? 45 : 0;            endfunction
  function automatic int p_hs(input int d);           return (d == 0) ? 4 : 4;             endfunction
  function automatic int p_rc(input int d);           return (d == 0) ? 32 : 4;            endfunction
  function automatic int p_mw(input int d);           return (d == 0) ? 9 : 0;             endfunction
  function automatic logic [31:0] p_base(input int d); return (d == 0) ? 32'h0 : 32'h100;  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    run_dump_sequencer #(
      .MAX_CYCLES  (g == 0 ? 45 : 0),
      .HALT_STABLE (4),
      .REG_COUNT   (g == 0 ? 32 : 4),
      .MEM_WORDS   (g == 0 ? 9 : 0),
      .DATA_BASE   (g == 0 ? 32'h0 : 32'h100),
      .CNT_W       (32)
    ) u_dut (
      .clk         (clk),
      .rst         (rst[g]),
      .pc          (pc[g]),
      .pc_valid    (pc_valid[g]),
      .ext_trig    (ext_trig[g]),
      .cpu_freeze  (cpu_freeze[g]),
      .rf_raddr    (rf_raddr[g]),
      .rf_rdata    (rf_rdata[g]),
      .dm_raddr    (dm_raddr[g]),
      .dm_rdata    (dm_rdata[g]),
      .dump_valid  (dump_valid[g]),
      .dump_ready  (dump_ready[g]),
      .dump_kind   (dump_kind[g]),
      .dump_index  (dump_index[g]),
      .dump_data   (dump_data[g]),
      .dump_cause  (dump_cause[g]),
      .done        (done[g]),
      .cycle_count (cycle_count[g])
    );
    assign rf_rdata[g] = rfv(rf_raddr[g]);
    assign dm_rdata[g] = memv(dm_raddr[g]);
  end

  int errors = 0;
  int checks = 0;
  int cur    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: phase 0 = running, 1 = dumping, 2 = finished.
  int          m_phase, m_cyc, m_rep, m_cause, m_beat;
  logic [31:0] m_last;

  initial begin
    int d, trig, ei;
    logic halt_now;
    logic [31:0] ea, ed;
    forever begin
      @(negedge clk);
      d = cur;
      if (rst[d]) begin
        chk("rst_freeze", 32'(cpu_freeze[d]), 32'd0);
        chk("rst_valid",  32'(dump_valid[d]), 32'd0);
        chk("rst_done",   32'(done[d]), 32'd0);
        chk("rst_cause",  32'(dump_cause[d]), 32'd0);
        chk("rst_cycles", cycle_count[d], 32'd0);
        chk("rst_rfaddr", 32'(rf_raddr[d]), 32'd0);
        chk("rst_dmaddr", dm_raddr[d], p_base(d));
        chk("rst_kind",   32'(dump_kind[d]), 32'd0);
        chk("rst_index",  32'(dump_index[d]), 32'd0);
        chk("rst_data",   dump_data[d], 32'd0);
        m_phase = 0; m_cyc = 0; m_rep = 0; m_cause = 0; m_beat = 0; m_last = 32'd0;
      end else begin
        chk("freeze", 32'(cpu_freeze[d]), 32'(m_phase != 0));
        chk("done",   32'(done[d]), 32'(m_phase == 2));
        chk("valid",  32'(dump_valid[d]), 32'(m_phase == 1));
        chk("cause",  32'(dump_cause[d]), 32'(m_cause));
        chk("cycles", cycle_count[d], 32'(m_cyc));
        if (m_phase == 1) begin
          if (m_beat < p_rc(d)) begin
            ed = (m_beat == 0) ? 32'd0 : rfv(5'(m_beat));
            chk("reg_kind",  32'(dump_kind[d]), 32'd0);
            chk("reg_index", 32'(dump_index[d]), 32'(m_beat));
            chk("reg_addr",  32'(rf_raddr[d]), 32'(m_beat));
            chk("reg_data",  dump_data[d], ed);
          end else begin
            ei = m_beat - p_rc(d);
            ea = p_base(d) + 32'(4 * ei);
            chk("mem_kind",  32'(dump_kind[d]), 32'd1);
            chk("mem_index", 32'(dump_index[d]), 32'(ei));
            chk("mem_addr",  dm_raddr[d], ea);
            chk("mem_data",  dump_data[d], memv(ea));
          end
        end
        // Advance the model with the inputs the next rising edge will sample.
        if (m_phase == 0) begin
          m_cyc++;
          halt_now = 1'b0;
          if (pc_valid[d]) begin
            if (pc[d] == m_last) begin
              if (m_rep < p_hs(d)) begin
                m_rep++;
                if (m_rep == p_hs(d)) halt_now = 1'b1;
              end
            end else begin
              m_rep = 0;
            end
            m_last = pc[d];
          end
          if (ext_trig[d])                           trig = 3;
          else if (p_max(d) != 0 && m_cyc == p_max(d)) trig = 1;
          else if (halt_now)                         trig = 2;
          else                                       trig = 0;
          if (trig != 0) begin
            m_phase = 1; m_cause = trig; m_beat = 0;
          end
        end else if (m_phase == 1) begin
          if (dump_ready[d]) begin
            m_beat++;
            if (m_beat == p_rc(d) + p_mw(d)) m_phase = 2;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    for (int i = 0; i < NDUT; i++) begin
      rst[i] = 1'b1; pc[i] = 32'd0; pc_valid[i] = 1'b0; ext_trig[i] = 1'b0; dump_ready[i] = 1'b0;
    end
    cur = d;
    step();
    step();
    rst[d] = 1'b0;
  endtask

  int beats, freeze_at, done_at;
  logic [31:0] r1_data;

  // pc_mode: 0 distinct PCs, 1 PC parked at 0x3040, 2 random between two PCs.
  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run_dump(input int d, input int budget, input int pc_mode, input int ready_mode,
                          input int ext_at);
    int n;
    n = 0; beats = 0; freeze_at = -1; done_at = -1; r1_data = 32'hFFFF_FFFF;
    while (done_at < 0 && n < budget) begin
      case (pc_mode)
        0:       begin pc[d] = 32'h1000 + 32'(4 * n); pc_valid[d] = 1'($urandom_range(0, 1)); end
        1:       begin pc[d] = 32'h3040; pc_valid[d] = 1'b1; end
        default: begin
          pc[d] = ($urandom_range(0, 1) == 0) ? 32'h3040 : 32'h3044;
          pc_valid[d] = ($urandom_range(0, 3) != 0);
        end
      endcase
      case (ready_mode)
        0:       dump_ready[d] = 1'b1;
        1:       dump_ready[d] = (n % 4 == 0) || (n % 4 == 3);
        default: dump_ready[d] = 1'($urandom_range(0, 1));
      endcase
      ext_trig[d] = (n == ext_at);
      #2;
      if (dump_valid[d] && dump_ready[d]) beats++;
      if (dump_valid[d] && dump_kind[d] == 1'b0 && dump_index[d] == 8'd1) r1_data = dump_data[d];
      step();
      n++;
      if (cpu_freeze[d] && freeze_at < 0) freeze_at = n;
      if (done[d] && done_at < 0) done_at = n;
    end
    ext_trig[d] = 1'b0;
    if (done_at < 0) chk("timeout_done", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < NDUT; i++) rst[i] = 1'b1;

    // Cycle limit with a running CPU and an always-ready consumer.
    do_reset(0);
    run_dump(0, 300, 0, 0, -1);
    chk("lim_freeze_at", 32'(freeze_at), 32'd45);
    chk("lim_cause", 32'(dump_cause[0]), 32'd1);
    chk("lim_cycles", cycle_count[0], 32'd45);
    chk("lim_beats", 32'(beats), 32'd41);
    chk("lim_done_at", 32'(done_at), 32'd86);

    // Backpressure with the 1,0,0,1 ready pattern, random PCs so a halt may fire first.
    do_reset(0);
    run_dump(0, 600, 2, 1, -1);
    chk("bp_beats", 32'(beats), 32'd41);
    chk("bp_done", 32'(done[0]), 32'd1);

    // Random ready on the cycle-limit path.
    do_reset(0);
    run_dump(0, 600, 0, 2, -1);
    chk("rnd_beats", 32'(beats), 32'd41);
    chk("rnd_cause", 32'(dump_cause[0]), 32'd1);

    // External trigger coincides with the cycle limit; later triggers in DONE are ignored.
    do_reset(0);
    run_dump(0, 300, 0, 0, 44);
    chk("prio_cause", 32'(dump_cause[0]), 32'd3);
    chk("prio_freeze_at", 32'(freeze_at), 32'd45);
    ext_trig[0] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    ext_trig[0] = 1'b0;
    chk("prio_done_hold", 32'(done[0]), 32'd1);
    chk("prio_valid_low", 32'(dump_valid[0]), 32'd0);
    chk("prio_cause_hold", 32'(dump_cause[0]), 32'd3);

    // Reset in the middle of the register phase.
    do_reset(0);
    ext_trig[0] = 1'b1;
    dump_ready[0] = 1'b1;
    step();
    ext_trig[0] = 1'b0;
    for (int i = 0; i < 10; i++) step();
    dump_ready[0] = 1'b0;
    #1;
    chk("mid_index", 32'(dump_index[0]), 32'd10);
    chk("mid_cycles", cycle_count[0], 32'd1);
    rst[0] = 1'b1;
    #1;
    chk("mid_rst_freeze", 32'(cpu_freeze[0]), 32'd0);
    chk("mid_rst_valid", 32'(dump_valid[0]), 32'd0);
    chk("mid_rst_index", 32'(dump_index[0]), 32'd0);
    step();
    step();
    rst[0] = 1'b0;
    step();
    step();
    step();
    chk("mid_restart_cycles", cycle_count[0], 32'd3);

    // Halt detection on the small configuration with random backpressure.
    do_reset(1);
    run_dump(1, 200, 1, 2, -1);
    chk("halt_freeze_at", 32'(freeze_at), 32'd5);
    chk("halt_cause", 32'(dump_cause[1]), 32'd2);
    chk("halt_cycles", cycle_count[1], 32'd5);
    chk("halt_beats", 32'(beats), 32'd4);
    chk("halt_r1", r1_data, 32'h1101_0111);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
